// File: rtl/instr_fetch_responder_pkg.sv
// Shared constants, state type and demo program for the simple processor's
// instruction-fetch path.
package simple_proc_pkg;

   localparam int unsigned INSTR_W = 12;
   localparam int unsigned PC_W    = 3;
   localparam int unsigned DEPTH   = 1 << PC_W;

   localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

   typedef enum logic {
      IDLE,
      ACK
   } fetch_state_t;

   localparam logic [INSTR_W-1:0] PRELOAD_PROG [0:DEPTH-1] = '{
      12'h1A0, 12'h2B1, 12'h3C2, 12'h4D3,
      12'h5E4, 12'h6F5, 12'h706, 12'hF00
   };

endpackage

// File: rtl/instr_fetch_responder_store.sv
// Program store: DEPTH x INSTR_W register file, one sync write, one comb read.
// INSTR_PRELOAD_EN selects preload-on-reset of the demo program instead of zero.
module instr_store
   import simple_proc_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned INSTR_W = 12,
   parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (!reset) begin
`ifdef INSTR_PRELOAD_EN
         mem <= PRELOAD_PROG;
`else
         mem <= '{default: '0};
`endif
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_responder.sv
// Fetch responder: req/ack instruction supply plus switch-driven program loads.
// INSTR_PRELOAD_EN: reset loads the demo program and sets prog_len to DEPTH.
module instr_fetch_responder
   import simple_proc_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned INSTR_W = 12
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_req,
   input  logic [PC_W-1:0]    fetch_pc,
   output logic               fetch_ack,
   output logic [INSTR_W-1:0] instr,
   output logic               end_of_prog,
   input  logic               load_en,
   input  logic [PC_W-1:0]    load_addr,
   input  logic [INSTR_W-1:0] load_data,
   output logic [PC_W:0]      prog_len,
   output logic               load_overrun,
   output logic               busy
);

   fetch_state_t       state_q, state_d;
   logic               pend_q;
   logic [PC_W-1:0]    pend_addr_q;
   logic [INSTR_W-1:0] pend_data_q;

   logic               do_write;
   logic               do_fetch;
   logic               pc_valid;
   logic [PC_W:0]      wr_len;
   logic [INSTR_W-1:0] rd_data;

   instr_store #(
      .DEPTH   (DEPTH),
      .INSTR_W (INSTR_W),
      .ADDR_W  (PC_W)
   ) u_store (
      .clk   (clk),
      .reset (reset),
      .we    (do_write),
      .waddr (pend_addr_q),
      .wdata (pend_data_q),
      .raddr (fetch_pc),
      .rdata (rd_data)
   );

   assign pc_valid = {1'b0, fetch_pc} < prog_len;
   assign wr_len   = {1'b0, pend_addr_q} + 1'b1;
   assign busy     = (state_q != IDLE) || pend_q;

   // A pending load always wins the IDLE slot; the fetch waits one cycle.
   always_comb begin
      state_d  = state_q;
      do_write = 1'b0;
      do_fetch = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_q) begin
               do_write = 1'b1;
            end else if (fetch_req) begin
               do_fetch = 1'b1;
               state_d  = ACK;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         fetch_ack    <= 1'b0;
         instr        <= '0;
         end_of_prog  <= 1'b0;
         load_overrun <= 1'b0;
         pend_q       <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
`ifdef INSTR_PRELOAD_EN
         prog_len     <= (PC_W+1)'(DEPTH);
`else
         prog_len     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         fetch_ack <= do_fetch;

         if (do_fetch) begin
            instr       <= pc_valid ? rd_data : NOP_INSTR;
            end_of_prog <= !pc_valid;
         end

         if (do_write && (wr_len > prog_len)) begin
            prog_len <= wr_len;
         end

         // A slot draining this cycle can accept the next strobe directly.
         if (load_en && (!pend_q || do_write)) begin
            pend_q      <= 1'b1;
            pend_addr_q <= load_addr;
            pend_data_q <= load_data;
         end else begin
            if (do_write) begin
               pend_q <= 1'b0;
            end
            if (load_en) begin
               load_overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Self-checking bench for instr_fetch_responder against a transaction-level
// model of the program store (array + length), directed and random steps.
module tb_instr_fetch_responder;
   import simple_proc_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        fetch_req = 1'b0;
   logic [2:0]  fetch_pc = '0;
   logic        fetch_ack;
   logic [11:0] instr;
   logic        end_of_prog;
   logic        load_en = 1'b0;
   logic [2:0]  load_addr = '0;
   logic [11:0] load_data = '0;
   logic [3:0]  prog_len;
   logic        load_overrun;
   logic        busy;

   instr_fetch_responder #(
      .DEPTH   (8),
      .INSTR_W (12)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .fetch_req    (fetch_req),
      .fetch_pc     (fetch_pc),
      .fetch_ack    (fetch_ack),
      .instr        (instr),
      .end_of_prog  (end_of_prog),
      .load_en      (load_en),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .prog_len     (prog_len),
      .load_overrun (load_overrun),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [11:0] model_mem [0:7];
   int          model_len;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
`ifdef INSTR_PRELOAD_EN
         model_mem[i] = PRELOAD_PROG[i];
`else
         model_mem[i] = 12'h000;
`endif
      end
`ifdef INSTR_PRELOAD_EN
      model_len = 8;
`else
      model_len = 0;
`endif
   endtask

   task automatic model_write(input int addr, input logic [11:0] data);
      model_mem[addr] = data;
      if (addr + 1 > model_len) model_len = addr + 1;
   endtask

   function automatic logic [11:0] exp_instr(input int pc);
      return (pc < model_len) ? model_mem[pc] : 12'h000;
   endfunction

   // Starts and ends at a negedge; returns with the load pending in the DUT.
   task automatic do_load(input int addr, input logic [11:0] data);
      load_en   = 1'b1;
      load_addr = 3'(addr);
      load_data = data;
      @(negedge clk);
      load_en = 1'b0;
      model_write(addr, data);
   endtask

   task automatic do_fetch(input string tag, input int pc, input int exp_lat);
      int lat;
      logic seen;
      logic [11:0] e_instr;
      e_instr = exp_instr(pc);
      fetch_req = 1'b1;
      fetch_pc  = 3'(pc);
      lat  = 0;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge clk);
         lat++;
         if (fetch_ack) seen = 1'b1;
      end
      fetch_req = 1'b0;
      check({tag, "_ack_seen"}, 32'(seen), 1);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_instr"}, 32'(instr), 32'(e_instr));
      check({tag, "_eop"}, 32'(end_of_prog), (pc >= model_len) ? 1 : 0);
      check({tag, "_prog_len"}, 32'(prog_len), 32'(model_len));
      @(negedge clk);
      check({tag, "_ack_pulse"}, 32'(fetch_ack), 0);
   endtask

   initial begin
      logic [11:0] d1, d2, d;
      int a;

      repeat (3) @(negedge clk);
      model_reset();
      check("rst_ack", 32'(fetch_ack), 0);
      check("rst_instr", 32'(instr), 0);
      check("rst_eop", 32'(end_of_prog), 0);
      check("rst_overrun", 32'(load_overrun), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_prog_len", 32'(prog_len), 32'(model_len));
      reset = 1'b1;
      @(negedge clk);

      // basic load then fetch
      do_load(0, 12'hA53);
      check("load0_busy_pend", 32'(busy), 1);
      @(negedge clk);
      check("load0_prog_len", 32'(prog_len), 32'(model_len));
      check("load0_busy_done", 32'(busy), 0);
      do_fetch("fetch0", 0, 1);
      do_fetch("fetch5_oob", 5, 1);

      // top address, then overwrite it
      do_load(7, 12'h3C7);
      @(negedge clk);
      check("load7_prog_len", 32'(prog_len), 8);
      do_load(7, 12'h111);
      @(negedge clk);
      check("reload7_prog_len", 32'(prog_len), 8);
      do_fetch("fetch7", 7, 1);

      // load strobe arriving while the responder is in ACK
      fetch_req = 1'b1;
      fetch_pc  = 3'd1;
      @(negedge clk);
      check("ackload_ack", 32'(fetch_ack), 1);
      check("ackload_instr", 32'(instr), 32'(exp_instr(1)));
      fetch_req = 1'b0;
      do_load(4, 12'h4B4);
      check("ackload_busy_pend", 32'(busy), 1);
      check("ackload_len_before", 32'(prog_len), 8);
      @(negedge clk);
      check("ackload_busy_done", 32'(busy), 0);
      do_fetch("fetch4", 4, 1);

      // overrun: pend captured with the fetch, second strobe hits ACK
      d1 = 12'($urandom);
      d2 = ~d1;
      fetch_req = 1'b1;
      fetch_pc  = 3'd0;
      load_en   = 1'b1;
      load_addr = 3'd3;
      load_data = d1;
      @(negedge clk);
      check("ovr_ack", 32'(fetch_ack), 1);
      check("ovr_instr", 32'(instr), 32'(exp_instr(0)));
      check("ovr_busy_ack", 32'(busy), 1);
      fetch_req = 1'b0;
      load_data = d2;
      @(negedge clk);
      load_en = 1'b0;
      check("ovr_flag", 32'(load_overrun), 1);
      check("ovr_busy_pend", 32'(busy), 1);
      model_write(3, d1);
      @(negedge clk);
      check("ovr_busy_done", 32'(busy), 0);
      do_fetch("ovr_fetch3", 3, 1);
      check("ovr_sticky", 32'(load_overrun), 1);

      // load pending and fetch in the same IDLE cycle: write first
      do_load(2, 12'h5A2);
      do_fetch("collide_fetch2", 2, 2);

      // random mix
      for (int it = 0; it < 24; it++) begin
         a = int'($urandom_range(0, 7));
         d = 12'($urandom);
         case ($urandom_range(0, 2))
            0: begin
               do_load(a, d);
               @(negedge clk);
            end
            1: do_fetch("rnd_fetch", a, 1);
            default: begin
               do_load(a, d);
               do_fetch("rnd_collide", int'($urandom_range(0, 7)), 2);
            end
         endcase
      end

      // reset while in ACK with a load pending
      fetch_req = 1'b1;
      fetch_pc  = 3'd0;
      load_en   = 1'b1;
      load_addr = 3'd6;
      load_data = 12'hEEE;
      @(negedge clk);
      check("rstack_ack", 32'(fetch_ack), 1);
      reset     = 1'b0;
      fetch_req = 1'b0;
      load_en   = 1'b0;
      @(negedge clk);
      model_reset();
      check("rstack_ack_cleared", 32'(fetch_ack), 0);
      check("rstack_busy", 32'(busy), 0);
      check("rstack_prog_len", 32'(prog_len), 32'(model_len));
      check("rstack_overrun", 32'(load_overrun), 0);
      reset = 1'b1;
      @(negedge clk);
      check("rstack_no_ack", 32'(fetch_ack), 0);
      do_fetch("rstack_fetch0", 0, 1);
      do_fetch("rstack_fetch6", 6, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_fetch_responder.md
# instr_fetch_responder

Instruction-supply responder that serves the control unit's fetch requests. It holds the 8-entry, 12-bit program store, indexed by the control unit's 3-bit PC. It returns one registered instruction per request through a req/ack handshake. It also accepts program loads from the board switches, strobed by a debounced button, so a program can be entered before or between runs.

## Interface
Parameters
- DEPTH, 8: program store entries; fixed to 2^PC_W.
- INSTR_W, 12: instruction width; matches the switch bank.

Ports
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- fetch_req  in  1  control unit requests instruction at fetch_pc; held until fetch_ack.
- fetch_pc  in  3  PC_out from control unit; must be stable while fetch_req is high.
- fetch_ack  out  1  one-cycle pulse; instr/end_of_prog valid this cycle and held until the next ack.
- instr  out  12  fetched instruction.
- end_of_prog  out  1  registered with instr; 1 when fetch_pc >= prog_len (instr forced to NOP).
- load_en  in  1  debounced single-cycle load strobe.
- load_addr  in  3  store address for the load.
- load_data  in  12  instruction word from the switches.
- prog_len  out  4  number of valid instructions, 0..8.
- load_overrun  out  1  sticky; a load strobe was dropped.
- busy  out  1  high when state != IDLE or a load is pending.

## Operation
- FSM states: IDLE, ACK.
- Load capture happens in any state.
  - load_en=1 with no pending load, or with the pending load draining this cycle: capture addr/data, set pend.
  - load_en=1 with pend set and not draining: drop the strobe, set load_overrun (cleared only by reset).
- IDLE with pend=1:
  - Write mem[pend_addr] <= pend_data.
  - prog_len <= max(prog_len, pend_addr+1).
  - Clear pend; stay IDLE.
  - Load has priority over fetch; any fetch is serviced the next IDLE cycle.
- IDLE with pend=0 and fetch_req=1:
  - If fetch_pc < prog_len: instr <= mem[fetch_pc], end_of_prog <= 0.
  - Else: instr <= NOP (12'h000), end_of_prog <= 1.
  - fetch_ack <= 1; go to ACK.
- ACK: fetch_ack <= 0; go to IDLE. fetch_req is ignored in ACK.
- Arithmetic: pend_addr+1 is computed at 4 bits, so address 7 gives prog_len 8 with no wrap. The fetch_pc vs prog_len compare is unsigned at 4 bits.
- Reloading an existing address overwrites it; prog_len does not shrink.

## Timing
- Fetch latency: req sampled in IDLE at cycle t gives fetch_ack=1 in cycle t+1 and IDLE in t+2. Minimum fetch period is 2 cycles.
- Requester deasserts fetch_req no later than cycle t+2. A req still high in t+2 starts a new fetch.
- Load latency: strobe at t, pend set in t+1, written at the end of t+1 if IDLE. A fetch of that address from t+2 returns the new word.
- Load and fetch in the same IDLE cycle with pend set: write first, fetch sampled next cycle, ack one cycle later than normal.
- Reset values: fetch_ack 0, instr 0, end_of_prog 0, load_overrun 0, busy 0, pend 0, state IDLE. Memory and prog_len reset values are listed under Configuration.
- Reset asserted mid-fetch (in ACK) or with a load pending: all state reset next cycle. The pending load is discarded and no ack is issued.

## Configuration
- INSTR_PRELOAD_EN defined: reset loads mem with the package demo program PRELOAD_PROG[0:7]; prog_len resets to 8.
- INSTR_PRELOAD_EN undefined: reset clears mem to 0; prog_len resets to 0.

## Structure
- Package simple_proc_pkg:
  - INSTR_W, PC_W, DEPTH.
  - NOP_INSTR constant.
  - fetch_state_t enum {IDLE, ACK}.
  - PRELOAD_PROG array constant.
- Sub-module instr_store: DEPTH x INSTR_W register file with one synchronous write port, one combinational read port and a reset-to-preload/zero input. The top holds the FSM, load capture, prog_len and flags.

## Test plan
- Reset without macro; load_en addr=0 data=12'hA53; then fetch_pc=0 req → ack 1 cycle after sampling; instr=12'hA53, end_of_prog=0, prog_len=1.
- Fetch pc=5 with prog_len=1 → instr=12'h000, end_of_prog=1.
- Load addr=7 → prog_len=8. Reload addr=7 with 12'h111 → prog_len stays 8; fetch returns 12'h111.
- load_en during ACK → write lands next IDLE cycle. A second load_en while pend is set and state is ACK → load_overrun=1, first data kept.
- Load pending and fetch_req in same IDLE cycle → write first, ack 2 cycles after req; the same address returns the new data.
- Reset asserted in ACK with pend set → next cycle fetch_ack=0, busy=0, prog_len=0 (or 8 with INSTR_PRELOAD_EN); fetch pc=0 returns PRELOAD_PROG[0] or NOP.
